// File: rtl/vector_instr_sequencer_pkg.sv
// Shared definitions for the vector instruction issue path: instruction
// width, opcode encodings and instruction field bounds.
package vp_pkg;

    localparam int INSTR_W = 13;

    typedef logic [INSTR_W-1:0] instr_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_MUL   = 2'b11;

    localparam int OPC_HI  = 12;
    localparam int OPC_LO  = 11;
    localparam int REG_HI  = 10;
    localparam int REG_LO  = 9;
    localparam int ADDR_HI = 8;
    localparam int ADDR_LO = 0;

endpackage

// File: rtl/vector_instr_sequencer_if.sv
// Instruction bus: host-side push handshake plus the instruction presented
// to the vector processor. The master side is the host, the slave side is
// the sequencer.
interface vector_instr_sequencer_if;
    import vp_pkg::*;

    instr_t in_instr;
    logic   in_valid;
    logic   in_ready;
    instr_t instruction;
    logic   instr_valid;

    modport master (
        output in_instr,
        output in_valid,
        input  in_ready,
        input  instruction,
        input  instr_valid
    );

    modport slave (
        input  in_instr,
        input  in_valid,
        output in_ready,
        output instruction,
        output instr_valid
    );

endinterface

// File: rtl/vector_instr_sequencer_fifo.sv
// Synchronous instruction FIFO with occupancy count. Push is ignored when
// full and pop is ignored when empty; full is taken from the registered
// count only, so a same-cycle pop never frees a slot for a push.
module vp_instr_fifo
    import vp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  instr_t           din,
    input  logic             pop,
    output instr_t           dout,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    instr_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vector_instr_sequencer.sv
// Instruction issue stage in front of the vector processor. Queues host
// instructions and presents each one for an opcode-dependent number of
// cycles before retiring it, issuing back-to-back when more are queued.
module vector_instr_sequencer
    import vp_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LD_CYC  = 3,
    parameter int ST_CYC  = 2,
    parameter int ADD_CYC = 2,
    parameter int MUL_CYC = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    vector_instr_sequencer_if.slave      bus,
    input  logic                         run,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [15:0]                  retired_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    // Hold length for an opcode; a zero-cycle setting still holds one cycle.
    function automatic logic [15:0] hold_len(input logic [1:0] op);
        int len;
        case (op)
            OP_LOAD:  len = LD_CYC;
            OP_STORE: len = ST_CYC;
            OP_ADD:   len = ADD_CYC;
            default:  len = MUL_CYC;
        endcase
        if (len < 1) begin
            len = 1;
        end
        return 16'(len);
    endfunction

    logic [0:0]  state;
    logic [15:0] hold_cnt;
    logic [15:0] retired_q;
    instr_t      instr_q;
    instr_t      fifo_dout;
    logic        fifo_full;
    logic        hold_last;
    logic        pop;
    logic        retire;

    vp_instr_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.in_valid),
        .din   (bus.in_instr),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full)
    );

    assign hold_last = (hold_cnt == 16'd0);
    assign retire    = (state == EXEC) && hold_last;
    assign pop       = run && (fifo_count != '0) && ((state == IDLE) || hold_last);

    assign bus.in_ready    = !fifo_full;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = (state == EXEC);
    assign busy            = (state == EXEC) || (fifo_count != '0);
    assign retired_count   = retired_q;

    // Issue FSM: load the head into the output register, count down its hold,
    // then retire and either chain the next instruction or fall back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hold_cnt  <= 16'd0;
            instr_q   <= '0;
            retired_q <= 16'd0;
        end else begin
            if (retire) begin
                retired_q <= retired_q + 16'd1;
            end
            if (pop) begin
                instr_q  <= fifo_dout;
                hold_cnt <= hold_len(fifo_dout[OPC_HI:OPC_LO]) - 16'd1;
                state    <= EXEC;
            end else if (retire) begin
                state <= IDLE;
            end else if (state == EXEC) begin
                hold_cnt <= hold_cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vector_instr_sequencer.sv
// Directed bench for vector_instr_sequencer. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_vector_instr_sequencer;
    import vp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        busy;
    logic [3:0]  fifo_count;
    logic [15:0] retired_count;

    int n_tests = 0;
    int n_fail  = 0;

    vector_instr_sequencer_if bus ();

    vector_instr_sequencer #(
        .DEPTH   (8),
        .LD_CYC  (3),
        .ST_CYC  (2),
        .ADD_CYC (2),
        .MUL_CYC (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .run           (run),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Wait on falling edges until the sequencer goes idle, bounded.
    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    instr_t seq3 [6];
    instr_t q4   [9];
    instr_t prev;
    int     ncap;

    initial begin
        seq3 = '{13'h1000, 13'h1000, 13'h1800, 13'h1800, 13'h1800, 13'h1800};
        q4   = '{13'h0001, 13'h0802, 13'h1003, 13'h1804, 13'h0005,
                 13'h0806, 13'h1007, 13'h1808, 13'h0009};

        reset        = 1'b0;
        run          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr", {19'd0, bus.instruction}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {28'd0, fifo_count}, 32'd0);
        check("rst_retired", {16'd0, retired_count}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Single load: 3-cycle hold, instruction kept after retire
        bus.in_instr = 13'h0003;
        bus.in_valid = 1'b1;
        run          = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("ld_not_yet", {31'd0, bus.instr_valid}, 32'd0);
        check("ld_queued", {28'd0, fifo_count}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ld_valid", {31'd0, bus.instr_valid}, 32'd1);
            check("ld_instr", {19'd0, bus.instruction}, 32'h0003);
        end
        @(negedge clk);
        check("ld_done_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("ld_done_instr", {19'd0, bus.instruction}, 32'h0003);
        check("ld_retired", {16'd0, retired_count}, 32'd1);
        check("ld_busy", {31'd0, busy}, 32'd0);

        // Add then mul back-to-back, no bubble
        bus.in_instr = 13'h1000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_instr = 13'h1800;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("am_valid", {31'd0, bus.instr_valid}, 32'd1);
            check("am_instr", {19'd0, bus.instruction}, {19'd0, seq3[i]});
            if (i == 5) begin
                check("am_busy_last", {31'd0, busy}, 32'd1);
            end
            @(negedge clk);
        end
        check("am_done_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("am_busy_drop", {31'd0, busy}, 32'd0);
        check("am_retired", {16'd0, retired_count}, 32'd3);

        // Fill with run=0: ninth push refused, then in-order drain
        run = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.in_instr = q4[i];
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        check("full_count", {28'd0, fifo_count}, 32'd8);
        check("full_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        run          = 1'b1;
        @(negedge clk);
        check("pop1_count", {28'd0, fifo_count}, 32'd7);
        check("pop1_ready", {31'd0, bus.in_ready}, 32'd1);
        check("pop1_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("order", {19'd0, bus.instruction}, {19'd0, q4[0]});
        prev = bus.instruction;
        ncap = 1;
        for (int n = 0; n < 60 && busy; n++) begin
            @(negedge clk);
            if (bus.instr_valid && bus.instruction != prev) begin
                if (ncap < 8) begin
                    check("order", {19'd0, bus.instruction}, {19'd0, q4[ncap]});
                end
                ncap++;
                prev = bus.instruction;
            end
        end
        check("fill_issued", ncap, 32'd8);
        check("fill_busy", {31'd0, busy}, 32'd0);
        check("fill_retired", {16'd0, retired_count}, 32'd11);

        // Retire counter wrap
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        check("wrap_preload", {16'd0, retired_count}, 32'hFFFF);
        @(negedge clk);
        bus.in_instr = 13'h1000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain("wrap_drain", 20);
        check("wrap_retired", {16'd0, retired_count}, 32'h0000);

        // run dropped during first cycle of a store with two queued
        run = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = 13'h0A10;
        @(negedge clk);
        bus.in_instr = 13'h1001;
        @(negedge clk);
        bus.in_instr = 13'h0802;
        @(negedge clk);
        bus.in_valid = 1'b0;
        run          = 1'b1;
        @(negedge clk);
        check("st_first_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("st_first_instr", {19'd0, bus.instruction}, 32'h0A10);
        run = 1'b0;
        @(negedge clk);
        check("st_second_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("st_second_instr", {19'd0, bus.instruction}, 32'h0A10);
        @(negedge clk);
        check("st_idle_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("st_idle_count", {28'd0, fifo_count}, 32'd2);
        check("st_retired", {16'd0, retired_count}, 32'd1);
        repeat (3) @(negedge clk);
        check("st_paused_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("st_paused_count", {28'd0, fifo_count}, 32'd2);
        check("st_paused_busy", {31'd0, busy}, 32'd1);
        run = 1'b1;
        drain("st_drain", 20);
        check("st_drain_retired", {16'd0, retired_count}, 32'd3);
        check("st_drain_instr", {19'd0, bus.instruction}, 32'h0802);

        // Asynchronous reset in the 2nd hold cycle of a mul, one queued behind it
        bus.in_instr = 13'h1805;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_instr = 13'h0003;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("ar_mul_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("ar_mul_instr", {19'd0, bus.instruction}, 32'h1805);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ar_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("ar_instr", {19'd0, bus.instruction}, 32'd0);
        check("ar_count", {28'd0, fifo_count}, 32'd0);
        check("ar_retired", {16'd0, retired_count}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ar_after_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("ar_after_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
